// File: rtl/btb_plru.sv
// rtl/btb_plru.sv - tree-PLRU replacement state for a set-associative BTB.
// Per-set touch updates, registered victim lookup and a one-set-per-cycle flush sweep.
module btb_plru #(
   parameter int SETS = 8,
   parameter int WAYS = 2,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS),
   localparam int NODES = WAYS - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_valid,
   input  logic [IDX_W-1:0] rd_index,
   input  logic [WAY_W-1:0] rd_way,
   input  logic             wr_valid,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [WAY_W-1:0] wr_way,
   input  logic [IDX_W-1:0] vic_index,
   output logic [WAY_W-1:0] vic_way,
   input  logic             flush,
   output logic             busy
);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t                         state_q;
   logic [IDX_W-1:0]               cnt_q;
   logic                           busy_q;
   logic [WAY_W-1:0]               vic_q;
   logic [SETS-1:0][NODES-1:0]     plru_q;
   logic [SETS-1:0][NODES-1:0]     plru_d;

   // Walk root to leaf along the way's address bits (MSB selects at the root).
   function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                              input logic [WAY_W-1:0] way);
      logic [2*WAYS-1:0] t;
      logic [WAY_W:0]    node;
      logic [WAY_W-1:0]  w;
      logic              b;
      t              = '0;
      t[NODES-1:0]   = bits;
      node           = '0;
      w              = way;
      for (int l = 0; l < WAY_W; l++) begin
         b       = w[WAY_W-1];
         t[node] = ~b;
         node    = {node[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(b);
         w       = w << 1;
      end
      return t[NODES-1:0];
   endfunction

   function automatic logic [WAY_W-1:0] victim(input logic [NODES-1:0] bits);
      logic [2*WAYS-1:0] t;
      logic [WAY_W:0]    node;
      logic [WAY_W-1:0]  v;
      logic              b;
      t            = '0;
      t[NODES-1:0] = bits;
      node         = '0;
      v            = '0;
      for (int l = 0; l < WAY_W; l++) begin
         b    = t[node];
         v    = (v << 1) | WAY_W'(b);
         node = {node[WAY_W-1:0], 1'b0} + (WAY_W+1)'(1) + (WAY_W+1)'(b);
      end
      return v;
   endfunction

   // Read update applied before write so the write wins on shared nodes.
   always_comb begin
      plru_d = plru_q;
      if (state_q == S_IDLE) begin
         if (rd_valid) plru_d[rd_index] = touch(plru_d[rd_index], rd_way);
         if (wr_valid) plru_d[wr_index] = touch(plru_d[wr_index], wr_way);
      end else begin
         plru_d[cnt_q] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         vic_q   <= '0;
         plru_q  <= '0;
      end else begin
         plru_q <= plru_d;
         vic_q  <= victim(plru_q[vic_index]);
         case (state_q)
            S_IDLE: begin
               if (flush) begin
                  state_q <= S_FLUSH;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_FLUSH: begin
               cnt_q <= cnt_q + IDX_W'(1);
               if (cnt_q == IDX_W'(SETS - 1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign vic_way = vic_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_btb_plru.sv
// tb/tb_btb_plru.sv - directed bench for btb_plru (8x4 instance plus an 8x2 instance).
module tb_btb_plru;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rd_valid = 1'b0, wr_valid = 1'b0, flush = 1'b0;
   logic [2:0] rd_index = '0, wr_index = '0, vic_index = '0;
   logic [1:0] rd_way = '0, wr_way = '0;
   logic [1:0] vic_way;
   logic       busy;

   logic       rd_valid2 = 1'b0, wr_valid2 = 1'b0, flush2 = 1'b0;
   logic [2:0] rd_index2 = '0, wr_index2 = '0, vic_index2 = '0;
   logic       rd_way2 = 1'b0, wr_way2 = 1'b0;
   logic       vic_way2;
   logic       busy2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   btb_plru #(.SETS(8), .WAYS(4)) dut (
      .clk(clk), .rst(rst),
      .rd_valid(rd_valid), .rd_index(rd_index), .rd_way(rd_way),
      .wr_valid(wr_valid), .wr_index(wr_index), .wr_way(wr_way),
      .vic_index(vic_index), .vic_way(vic_way),
      .flush(flush), .busy(busy)
   );

   btb_plru #(.SETS(8), .WAYS(2)) dut2 (
      .clk(clk), .rst(rst),
      .rd_valid(rd_valid2), .rd_index(rd_index2), .rd_way(rd_way2),
      .wr_valid(wr_valid2), .wr_index(wr_index2), .wr_way(wr_way2),
      .vic_index(vic_index2), .vic_way(vic_way2),
      .flush(flush2), .busy(busy2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_vic(input logic [2:0] idx, output logic [1:0] v);
      vic_index = idx;
      step();
      v = vic_way;
   endtask

   task automatic do_touch(input logic rv, input logic [2:0] ri, input logic [1:0] rw,
                           input logic wv, input logic [2:0] wi, input logic [1:0] ww);
      rd_valid = rv; rd_index = ri; rd_way = rw;
      wr_valid = wv; wr_index = wi; wr_way = ww;
      step();
      rd_valid = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [1:0] v;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      for (int s = 0; s < 8; s++) begin
         read_vic(3'(s), v);
         total++;
         if (v !== 2'd0) begin bad++; $display("FAIL reset_vic set%0d got=%0d want=0", s, v); end
      end
      vic_index2 = 3'd0;
      step();
      total++;
      if (vic_way2 !== 1'b0) begin bad++; $display("FAIL reset_vic_w2 got=%b want=0", vic_way2); end
   endtask

   task automatic test_touch();
      logic [1:0] v;
      do_touch(1'b1, 3'd3, 2'd0, 1'b0, 3'd0, 2'd0);
      read_vic(3'd3, v);
      total++;
      if (v !== 2'd2) begin bad++; $display("FAIL rd_touch got=%0d want=2", v); end
      do_touch(1'b0, 3'd0, 2'd0, 1'b1, 3'd3, 2'd2);
      read_vic(3'd3, v);
      total++;
      if (v !== 2'd1) begin bad++; $display("FAIL wr_touch got=%0d want=1", v); end
   endtask

   task automatic test_latency();
      vic_index = 3'd4;
      do_touch(1'b1, 3'd4, 2'd0, 1'b0, 3'd0, 2'd0);
      total++;
      if (vic_way !== 2'd0) begin bad++; $display("FAIL no_bypass got=%0d want=0", vic_way); end
      step();
      total++;
      if (vic_way !== 2'd2) begin bad++; $display("FAIL latency1 got=%0d want=2", vic_way); end
   endtask

   task automatic test_same_set();
      logic [1:0] v;
      do_touch(1'b1, 3'd5, 2'd0, 1'b1, 3'd5, 2'd3);
      read_vic(3'd5, v);
      total++;
      if (v !== 2'd1) begin bad++; $display("FAIL same_set got=%0d want=1", v); end
      do_touch(1'b1, 3'd2, 2'd0, 1'b0, 3'd0, 2'd0);
      do_touch(1'b1, 3'd2, 2'd3, 1'b1, 3'd2, 2'd3);
      read_vic(3'd2, v);
      total++;
      if (v !== 2'd1) begin bad++; $display("FAIL same_way got=%0d want=1", v); end
   endtask

   task automatic test_diff_sets();
      logic [1:0] v;
      do_touch(1'b1, 3'd1, 2'd1, 1'b1, 3'd6, 2'd3);
      read_vic(3'd1, v);
      total++;
      if (v !== 2'd2) begin bad++; $display("FAIL diff_set1 got=%0d want=2", v); end
      read_vic(3'd6, v);
      total++;
      if (v !== 2'd0) begin bad++; $display("FAIL diff_set6 got=%0d want=0", v); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] v;
      do_touch(1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 2'd0);
      do_touch(1'b1, 3'd7, 2'd3, 1'b0, 3'd0, 2'd0);
      read_vic(3'd7, v);
      total++;
      if (v !== 2'd1) begin bad++; $display("FAIL back_to_back got=%0d want=1", v); end
   endtask

   task automatic test_flush();
      logic [1:0] v;
      int n;
      for (int s = 0; s < 8; s++) do_touch(1'b1, 3'(s), 2'd0, 1'b0, 3'd0, 2'd0);
      flush = 1'b1;
      step();
      rd_valid = 1'b1; rd_index = 3'd0; rd_way = 2'd0;
      wr_valid = 1'b1; wr_index = 3'd1; wr_way = 2'd0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
      flush = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0;
      total++;
      if (n !== 8) begin bad++; $display("FAIL flush_busy_cycles got=%0d want=8", n); end
      for (int s = 0; s < 8; s++) begin
         read_vic(3'(s), v);
         total++;
         if (v !== 2'd0) begin bad++; $display("FAIL flush_vic set%0d got=%0d want=0", s, v); end
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_refire got=%b want=0", busy); end
   endtask

   task automatic test_rst_mid_flush();
      logic [1:0] v;
      do_touch(1'b1, 3'd6, 2'd0, 1'b0, 3'd0, 2'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step(); step(); step();
      vic_index = 3'd6;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", busy); end
      step();
      rst = 1'b0;
      read_vic(3'd6, v);
      total++;
      if (v !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", v); end
      do_touch(1'b1, 3'd4, 2'd0, 1'b0, 3'd0, 2'd0);
      read_vic(3'd4, v);
      total++;
      if (v !== 2'd2) begin bad++; $display("FAIL post_rst_touch got=%0d want=2", v); end
   endtask

   task automatic test_ways2();
      rd_valid2 = 1'b1; rd_index2 = 3'd0; rd_way2 = 1'b0; vic_index2 = 3'd0;
      step();
      rd_valid2 = 1'b0;
      step();
      total++;
      if (vic_way2 !== 1'b1) begin bad++; $display("FAIL w2_touch0 got=%b want=1", vic_way2); end
      wr_valid2 = 1'b1; wr_index2 = 3'd0; wr_way2 = 1'b1;
      step();
      wr_valid2 = 1'b0;
      step();
      total++;
      if (vic_way2 !== 1'b0) begin bad++; $display("FAIL w2_touch1 got=%b want=0", vic_way2); end
   endtask

   initial begin
      test_reset();
      test_touch();
      test_latency();
      test_same_set();
      test_diff_sets();
      test_back_to_back();
      test_flush();
      test_rst_mid_flush();
      test_ways2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
